// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: FSM encoding,
// default 640x480@60 timing and the counter width.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } vga_state_e;

  localparam int VGA_CNT_W = 10;

  localparam int VGA_TOTAL_COLS    = 800;
  localparam int VGA_TOTAL_ROWS    = 525;
  localparam int VGA_ACTIVE_COLS   = 640;
  localparam int VGA_ACTIVE_ROWS   = 480;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_SYNC_WIDTH  = 96;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_SYNC_WIDTH  = 2;
  localparam bit VGA_SYNC_POL      = 1'b0;

  // True when value lies in the half-open window [start, start+width).
  function automatic logic in_window(input int value, input int start, input int width);
    return (value >= start) && (value < start + width);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis: wrapping position counter plus look-ahead compares
// on the next count so the parent can register aligned flags.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_WIDTH = 96
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  output logic [VGA_CNT_W-1:0] count,
  output logic                 last,
  output logic                 nxt_zero,
  output logic                 nxt_active,
  output logic                 nxt_sync
);

  localparam logic [VGA_CNT_W-1:0] LAST_CNT = VGA_CNT_W'(TOTAL - 1);

  logic [VGA_CNT_W-1:0] cnt_q;
  logic [VGA_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count      = cnt_q;
  assign last       = (cnt_q == LAST_CNT);
  assign nxt_zero   = (cnt_d == '0);
  assign nxt_active = (int'(cnt_d) < ACTIVE);
  assign nxt_sync   = in_window(int'(cnt_d), SYNC_START, SYNC_WIDTH);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing master: porch-inserted syncs, aligned counts and
// frame markers, with run/stop honoured only on frame boundaries.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS    = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS    = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = VGA_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH  = VGA_H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH  = VGA_V_SYNC_WIDTH,
  parameter bit SYNC_POL      = VGA_SYNC_POL
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Enable,
  output logic                 o_HSync,
  output logic                 o_VSync,
  output logic                 o_Active,
  output logic [VGA_CNT_W-1:0] o_Col_Count,
  output logic [VGA_CNT_W-1:0] o_Row_Count,
  output logic                 o_Frame_Start,
  output logic [15:0]          o_Frame_Count,
  output logic                 o_Running
);

  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
    $fatal(1, "vga_timing_gen: horizontal timing exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
    $fatal(1, "vga_timing_gen: vertical timing exceeds TOTAL_ROWS");
  end
  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_size
    $fatal(1, "vga_timing_gen: raster larger than 1024 in an axis");
  end

  vga_state_e  state_q, state_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        fstart_q, fstart_d;
  logic        running_q, running_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic advance;
  logic clear;
  logic frame_done;
  logic last_pix;

  logic                 col_last, col_nxt_zero, col_nxt_active, col_nxt_sync;
  logic                 row_last, row_nxt_zero, row_nxt_active, row_nxt_sync;
  logic [VGA_CNT_W-1:0] col_count, row_count;

  vga_axis_counter #(
    .TOTAL      (TOTAL_COLS),
    .ACTIVE     (ACTIVE_COLS),
    .SYNC_START (ACTIVE_COLS + H_FRONT_PORCH),
    .SYNC_WIDTH (H_SYNC_WIDTH)
  ) u_col (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .clear      (clear),
    .advance    (advance),
    .count      (col_count),
    .last       (col_last),
    .nxt_zero   (col_nxt_zero),
    .nxt_active (col_nxt_active),
    .nxt_sync   (col_nxt_sync)
  );

  vga_axis_counter #(
    .TOTAL      (TOTAL_ROWS),
    .ACTIVE     (ACTIVE_ROWS),
    .SYNC_START (ACTIVE_ROWS + V_FRONT_PORCH),
    .SYNC_WIDTH (V_SYNC_WIDTH)
  ) u_row (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .clear      (clear),
    .advance    (advance & col_last),
    .count      (row_count),
    .last       (row_last),
    .nxt_zero   (row_nxt_zero),
    .nxt_active (row_nxt_active),
    .nxt_sync   (row_nxt_sync)
  );

  assign last_pix = col_last & row_last;

  // Enable has priority in STOP_PEND so a re-request on the final pixel
  // rolls straight into the next frame instead of dropping to IDLE.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clear = 1'b1;
        if (i_Enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (!i_Enable) begin
          state_d = ST_STOP_PEND;
        end
      end
      ST_STOP_PEND: begin
        if (i_Enable) begin
          state_d = ST_RUN;
          advance = 1'b1;
        end else if (last_pix) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  // Output flags are formed from the next counts so they land in the same
  // cycle as the pixel coordinates they describe.
  always_comb begin
    frame_done  = (state_q != ST_IDLE) && last_pix;
    running_d   = (state_d != ST_IDLE);
    hsync_d     = (running_d && col_nxt_sync) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = (running_d && row_nxt_sync) ? SYNC_POL : ~SYNC_POL;
    active_d    = running_d && col_nxt_active && row_nxt_active;
    fstart_d    = running_d && col_nxt_zero && row_nxt_zero;
    frame_cnt_d = frame_cnt_q + {15'd0, frame_done};
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      active_q    <= 1'b0;
      fstart_q    <= 1'b0;
      running_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      active_q    <= active_d;
      fstart_q    <= fstart_d;
      running_q   <= running_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Col_Count   = col_count;
  assign o_Row_Count   = row_count;
  assign o_Frame_Start = fstart_q;
  assign o_Frame_Count = frame_cnt_q;
  assign o_Running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; a linear-pixel-index model
// predicts every output after each clock edge.
module tb_vga_timing_gen;

  localparam int TC  = 40;
  localparam int TR  = 20;
  localparam int AC  = 32;
  localparam int AR  = 15;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam bit POL = 1'b0;
  localparam int N   = TC * TR;

  logic        clk;
  logic        rst;
  logic        en;
  logic        hsync, vsync, active, fstart, running;
  logic [9:0]  col, row;
  logic [15:0] fcount;

  int total;
  int bad;

  bit m_on;
  bit m_pend;
  int m_p;
  int m_frames;

  vga_timing_gen #(
    .TOTAL_COLS    (TC),
    .TOTAL_ROWS    (TR),
    .ACTIVE_COLS   (AC),
    .ACTIVE_ROWS   (AR),
    .H_FRONT_PORCH (HFP),
    .H_SYNC_WIDTH  (HSW),
    .V_FRONT_PORCH (VFP),
    .V_SYNC_WIDTH  (VSW),
    .SYNC_POL      (POL)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Enable      (en),
    .o_HSync       (hsync),
    .o_VSync       (vsync),
    .o_Active      (active),
    .o_Col_Count   (col),
    .o_Row_Count   (row),
    .o_Frame_Start (fstart),
    .o_Frame_Count (fcount),
    .o_Running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_p = 0; m_frames = 0;
  endtask

  // Model state: m_p is the linear pixel index of the current output,
  // m_pend marks that the current pixel is shown with a stop pending.
  task automatic model_tick(input bit e);
    if (!m_on) begin
      if (e) begin
        m_on = 1; m_p = 0; m_pend = 0;
      end
    end else begin
      if (m_p == N - 1) m_frames++;
      if (m_pend && !e && m_p == N - 1) begin
        m_on = 0; m_p = 0; m_pend = 0;
      end else begin
        m_p    = (m_p + 1) % N;
        m_pend = !e;
      end
    end
  endtask

  task automatic check_all();
    int c, r;
    bit hs, vs;
    c  = m_on ? m_p % TC : 0;
    r  = m_on ? m_p / TC : 0;
    hs = (m_on && c >= AC + HFP && c < AC + HFP + HSW) ? POL : !POL;
    vs = (m_on && r >= AR + VFP && r < AR + VFP + VSW) ? POL : !POL;
    chk("col",     32'(col),     32'(c));
    chk("row",     32'(row),     32'(r));
    chk("hsync",   32'(hsync),   32'(hs));
    chk("vsync",   32'(vsync),   32'(vs));
    chk("active",  32'(active),  32'(m_on && c < AC && r < AR));
    chk("fstart",  32'(fstart),  32'(m_on && m_p == 0));
    chk("running", 32'(running), 32'(m_on));
    chk("fcount",  32'(fcount),  32'(m_frames & 16'hFFFF));
  endtask

  task automatic step();
    @(posedge clk);
    model_tick(en);
    #1;
    check_all();
  endtask

  initial begin
    int hs_low, vs_low, fs_cnt, steps;
    total = 0;
    bad   = 0;
    model_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    repeat (3) step();

    // Start: first pixel is (0,0) with frame start and syncs deasserted.
    en = 1'b1;
    step();
    chk("first_fstart", 32'(fstart), 1);
    chk("first_active", 32'(active), 1);
    chk("first_hsync",  32'(hsync), 1);
    chk("first_vsync",  32'(vsync), 1);
    chk("first_run",    32'(running), 1);

    // One full frame: measure sync widths and frame-start pulses.
    hs_low = (row == 0 && hsync == POL) ? 1 : 0;
    vs_low = (vsync == POL) ? 1 : 0;
    fs_cnt = fstart ? 1 : 0;
    for (int i = 1; i < N; i++) begin
      step();
      if (row == 0 && hsync == POL) hs_low++;
      if (vsync == POL) vs_low++;
      if (fstart) fs_cnt++;
    end
    chk("hsync_width", 32'(hs_low), 32'(HSW));
    chk("vsync_width", 32'(vs_low), 32'(VSW * TC));
    chk("fstart_once", 32'(fs_cnt), 1);
    step();
    chk("frame_cnt_1", 32'(fcount), 1);
    chk("frame_wrap_fs", 32'(fstart), 1);

    // Drop enable at row 5: frame completes, then IDLE.
    for (int i = 0; i < N && row != 5; i++) step();
    chk("reach_row5", 32'(row), 5);
    en = 1'b0;
    steps = 0;
    for (int i = 0; i < N + 2 && running; i++) begin
      step();
      steps++;
    end
    chk("stop_len",     32'(steps), 32'(N - 5 * TC));
    chk("stop_running", 32'(running), 0);
    chk("stop_hsync",   32'(hsync), 1);
    repeat (3) step();
    chk("idle_col", 32'(col), 0);

    // One-cycle low pulse mid-line costs no pixels.
    en = 1'b1;
    step();
    for (int i = 0; i < 2 * TC && col != 10; i++) step();
    chk("reach_col10", 32'(col), 10);
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (5) step();
    chk("glitch_col", 32'(col), 16);
    chk("glitch_run", 32'(running), 1);

    // Randomised enable traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) < 85);
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 2 * N + 2 && running; i++) step();
    chk("rand_stop", 32'(running), 0);

    // One-cycle high pulse in IDLE runs exactly one frame.
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < N + 3; i++) step();
    chk("pulse_idle", 32'(running), 0);
    chk("pulse_frames", 32'(fcount), 32'(m_frames & 16'hFFFF));

    // Asynchronous reset mid-frame at (30,10).
    en = 1'b1;
    for (int i = 0; i < 2 * N && !(running && row == 10 && col == 30); i++) step();
    chk("reach_30_10", 32'(col), 30);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_fcount", 32'(fcount), 0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step();
    chk("restart_fs", 32'(fstart), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
